// File: rtl/rv_pkg.sv
// Shared RV32I/RV64I decode definitions: base opcodes, immediate formats,
// and skid-buffer occupancy states.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_decode_comb.sv
// Pure combinational immediate decode: instr + pc -> imm, format,
// illegal flag and pc-relative target.
module imm_decode_comb
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] target_o
);

    logic [31:0] imm32;
    logic        pc_rel;
    logic [2:0]  funct3;

    assign funct3 = instr_i[14:12];

    always_comb begin
        imm32     = '0;
        fmt_o     = FMT_ILL;
        illegal_o = 1'b0;
        pc_rel    = 1'b0;
        // Every listed opcode ends in 2'b11, so bad low bits fall to default.
        unique case (instr_i[6:0])
            OP_LOAD, OP_FENCE, OP_JALR, OP_SYSTEM: begin
                fmt_o = FMT_I;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_IMM: begin
                fmt_o = FMT_I;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm32 = {26'b0, (XLEN == 64) && instr_i[25],
                             instr_i[24:20]};
                end else begin
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            OP_STORE: begin
                fmt_o = FMT_S;
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                fmt_o  = FMT_B;
                pc_rel = 1'b1;
                imm32  = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0};
            end
            OP_LUI: begin
                fmt_o = FMT_U;
                imm32 = {instr_i[31:12], 12'b0};
            end
            OP_AUIPC: begin
                fmt_o  = FMT_U;
                pc_rel = 1'b1;
                imm32  = {instr_i[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt_o  = FMT_J;
                pc_rel = 1'b1;
                imm32  = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0};
            end
            OP_OP: begin
                fmt_o = FMT_R;
            end
            default: begin
                fmt_o     = FMT_ILL;
                illegal_o = 1'b1;
            end
        endcase
    end

    always_comb begin
        imm_o       = {XLEN{imm32[31]}};
        imm_o[31:0] = imm32;
        target_o    = pc_rel ? pc_i + imm_o : '0;
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a two-entry skid buffer;
// all outputs come straight from the main entry registers.
module imm_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } res_t;

    res_t       dec;
    res_t       main_q, main_d;
    res_t       skid_q, skid_d;
    buf_state_e state_q, state_d;

    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    logic            accept;
    logic            drain;

    imm_decode_comb #(
        .XLEN(XLEN)
    ) u_dec (
        .instr_i  (in_instr),
        .pc_i     (in_pc),
        .imm_o    (dec_imm),
        .fmt_o    (dec_fmt),
        .illegal_o(dec_illegal),
        .target_o (dec_target)
    );

    assign dec = '{
        instr:   in_instr,
        pc:      in_pc,
        imm:     dec_imm,
        target:  dec_target,
        fmt:     dec_fmt,
        illegal: dec_illegal
    };

    // in_ready is a pure decode of the state register.
    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            unique case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (drain && accept) begin
                        main_d = dec;
                    end else if (drain) begin
                        state_d = BUF_EMPTY;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = BUF_FULL;
                    end
                end
                BUF_FULL: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = BUF_ONE;
                    end
                end
                default: begin
                    state_d = BUF_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_instr   = main_q.instr;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_target  = main_q.target;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench: XLEN=32 and XLEN=64 stages share stimulus and are
// checked against a format-rule reference model.
module tb_imm_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] pc64 = '0;

    logic        rdy32, ov32, ill32;
    logic [31:0] ins32, pco32, imm32, tgt32;
    logic [2:0]  fmt32;
    logic        rdy64, ov64, ill64;
    logic [31:0] ins64;
    logic [63:0] pco64, imm64, tgt64;
    logic [2:0]  fmt64;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_pc(pc64[31:0]),
        .out_valid(ov32), .out_ready(out_ready),
        .out_instr(ins32), .out_pc(pco32), .out_imm(imm32),
        .out_fmt(fmt32), .out_illegal(ill32), .out_target(tgt32)
    );

    imm_decode_stage #(.XLEN(64)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_pc(pc64),
        .out_valid(ov64), .out_ready(out_ready),
        .out_instr(ins64), .out_pc(pco64), .out_imm(imm64),
        .out_fmt(fmt64), .out_illegal(ill64), .out_target(tgt64)
    );

    function automatic exp_t model(input logic [31:0] ins,
                                   input logic [63:0] pc, input int xl);
        exp_t   e;
        longint v;
        logic   rel;
        logic [63:0] mask;
        logic [2:0]  f3;
        v = 0;
        rel = 1'b0;
        f3 = ins[14:12];
        e.fmt = 3'd7;
        e.ill = 1'b0;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (ins[1:0] != 2'b11) begin
            e.ill = 1'b1;
        end else begin
            case (ins[6:0])
                7'b0000011, 7'b0001111, 7'b1100111, 7'b1110011: begin
                    e.fmt = 3'd1; v = $signed(ins[31:20]);
                end
                7'b0010011: begin
                    e.fmt = 3'd1;
                    if (f3 == 3'b001 || f3 == 3'b101)
                        v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                    else
                        v = $signed(ins[31:20]);
                end
                7'b0100011: begin
                    e.fmt = 3'd2; v = $signed({ins[31:25], ins[11:7]});
                end
                7'b1100011: begin
                    e.fmt = 3'd3; rel = 1'b1;
                    v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                end
                7'b0110111: begin
                    e.fmt = 3'd4; v = $signed({ins[31:12], 12'b0});
                end
                7'b0010111: begin
                    e.fmt = 3'd4; rel = 1'b1; v = $signed({ins[31:12], 12'b0});
                end
                7'b1101111: begin
                    e.fmt = 3'd5; rel = 1'b1;
                    v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
                end
                7'b0110011: e.fmt = 3'd0;
                default: e.ill = 1'b1;
            endcase
        end
        e.instr = ins;
        e.pc    = pc & mask;
        e.imm   = 64'(v) & mask;
        e.tgt   = rel ? ((e.pc + e.imm) & mask) : 64'h0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic cmp_tx(input string nm, input exp_t e,
                          input logic [31:0] i, input logic [63:0] pc,
                          input logic [63:0] imm, input logic [63:0] tgt,
                          input logic [2:0] f, input logic il);
        n_tests++;
        if (i !== e.instr || pc !== e.pc || imm !== e.imm ||
            tgt !== e.tgt || f !== e.fmt || il !== e.ill) begin
            n_fail++;
            $display("FAIL %s: got instr %h pc %h imm %h tgt %h fmt %0d ill %b; want instr %h pc %h imm %h tgt %h fmt %0d ill %b",
                     nm, i, pc, imm, tgt, f, il,
                     e.instr, e.pc, e.imm, e.tgt, e.fmt, e.ill);
        end
    endtask

    // Monitor: compare on each presented-and-accepted output, then log accepts.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (ov32 && out_ready) begin
                if (q32.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL x32_unexpected: got instr %h want none", ins32);
                end else begin
                    cmp_tx("x32_tx", q32.pop_front(), ins32, {32'b0, pco32},
                           {32'b0, imm32}, {32'b0, tgt32}, fmt32, ill32);
                end
            end
            if (ov64 && out_ready) begin
                if (q64.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL x64_unexpected: got instr %h want none", ins64);
                end else begin
                    cmp_tx("x64_tx", q64.pop_front(), ins64, pco64,
                           imm64, tgt64, fmt64, ill64);
                end
            end
            if (in_valid && rdy32) q32.push_back(model(in_instr, {32'b0, pc64[31:0]}, 32));
            if (in_valid && rdy64) q64.push_back(model(in_instr, pc64, 64));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [63:0] pc);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        pc64 = pc;
        while (!rdy32 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL offer_timeout: got in_ready 0 want 1");
        end
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0]  ops [12];
        logic [31:0] r;
        int k;
        ops = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111,
                7'b0100011, 7'b0110011, 7'b0110111, 7'b1100011,
                7'b1100111, 7'b1101111, 7'b1110011, 7'b0010011};
        r = $urandom;
        k = $urandom_range(0, 14);
        if (k < 12) r[6:0] = ops[k];
        return r;
    endfunction

    initial begin
        #3;
        chk("rst_valid", {63'b0, ov32}, 64'd0);
        chk("rst_ready", {63'b0, rdy32}, 64'd1);
        chk("rst_imm", {32'b0, imm32}, 64'd0);
        chk("rst_tgt64", tgt64, 64'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        offer(32'hFFF00093, 64'h0);
        chk("addi_imm32", {32'b0, imm32}, 64'hFFFF_FFFF);
        chk("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_fmt", {61'b0, fmt32}, 64'd1);
        chk("addi_tgt", {32'b0, tgt32}, 64'd0);
        offer(32'h40505013, 64'h0);
        chk("srai_imm", {32'b0, imm32}, 64'd5);
        offer(32'hFE000EE3, 64'h100);
        chk("beq_imm", {32'b0, imm32}, 64'hFFFF_FFFC);
        chk("beq_fmt", {61'b0, fmt32}, 64'd3);
        chk("beq_tgt", {32'b0, tgt32}, 64'hFC);
        offer(32'h0010006F, 64'hFFFF_F800);
        chk("jal_imm", {32'b0, imm32}, 64'h800);
        chk("jal_wrap", {32'b0, tgt32}, 64'h0);
        offer(32'h00000000, 64'h40);
        chk("ill_flag", {63'b0, ill32}, 64'd1);
        chk("ill_fmt", {61'b0, fmt32}, 64'd7);
        chk("ill_imm", {32'b0, imm32}, 64'd0);
        step();

        // Back-to-back stream into a stalled consumer.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00500093;
        step();
        in_instr = 32'h00A00093;
        step();
        chk("stall_ready_low", {63'b0, rdy32}, 64'd0);
        in_instr = 32'h00F00093;
        step();
        chk("stall_hold_instr", {32'b0, ins32}, 64'h00500093);
        step();
        chk("stall_hold_imm", {32'b0, imm32}, 64'd5);
        out_ready = 1'b1;
        chk("drain_first", {32'b0, imm32}, 64'd5);
        step();
        chk("drain_second", {32'b0, imm32}, 64'd10);
        chk("drain_ready", {63'b0, rdy32}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("drain_third", {32'b0, imm32}, 64'd15);
        step();
        chk("drain_empty", {63'b0, ov32}, 64'd0);

        // Flush while FULL, then flush of an acceptable offer in ONE.
        out_ready = 1'b0;
        offer(32'h00100093, 64'h10);
        offer(32'h00200093, 64'h14);
        in_valid = 1'b1;
        in_instr = 32'h00300093;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_full_valid", {63'b0, ov32}, 64'd0);
        chk("flush_full_ready", {63'b0, rdy32}, 64'd1);
        offer(32'h00400093, 64'h18);
        in_valid = 1'b1;
        in_instr = 32'h00500013;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_one_valid", {63'b0, ov64}, 64'd0);
        out_ready = 1'b1;
        offer(32'h00700093, 64'h20);
        chk("post_flush_instr", {32'b0, ins32}, 64'h00700093);

        // Asynchronous reset while FULL.
        step();
        out_ready = 1'b0;
        offer(32'h00800093, 64'h30);
        offer(32'h00900093, 64'h34);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'b0, ov32}, 64'd0);
        chk("arst_ready", {63'b0, rdy64}, 64'd1);
        chk("arst_instr", {32'b0, ins32}, 64'd0);
        chk("arst_imm64", imm64, 64'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        offer(32'h06300093, 64'h50);
        chk("arst_next_instr", {32'b0, ins32}, 64'h06300093);
        step();
        chk("arst_next_alone", {63'b0, ov32}, 64'd0);

        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rnd_instr();
            pc64      = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        chk("end_q32_empty", 64'(q32.size()), 64'd0);
        chk("end_q64_empty", 64'(q64.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
